// File: rtl/frame_update_scheduler.sv
// Per-frame update sequencer: on the trigger line start, kick units 0..3 in order,
// wait for each (with timeout), then pulse a commit to the display position latch.
module frame_update_scheduler #(
    parameter logic [9:0] TRIG_LINE = 10'd480,
    parameter int         TIMEOUT   = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hCount,
    input  logic [9:0] vCount,
    input  logic [3:0] unitDone,
    input  logic       clearFlags,
    output logic [3:0] unitStart,
    output logic       frameStart,
    output logic       busy,
    output logic [3:0] timeoutFlags,
    output logic       overrun,
    output logic [7:0] frameCount
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT0, S_WAIT1, S_WAIT2, S_WAIT3, S_COMMIT
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    logic        r_condPrev;
    logic [15:0] r_waitCnt;
    logic [3:0]  r_unitStart;
    logic        r_frameStart;
    logic [3:0]  r_timeoutFlags;
    logic        r_overrun;
    logic [7:0]  r_frameCount;

    logic       w_cond, w_tick, w_inWait, w_done, w_tmo, w_ovSet;
    logic [2:0] w_off;
    logic [1:0] w_idx;
    logic [3:0] w_toSet;

    assign w_cond   = (hCount == 10'd0) && (vCount == TRIG_LINE);
    assign w_tick   = w_cond && !r_condPrev;
    assign w_inWait = (r_state >= S_WAIT0) && (r_state <= S_WAIT3);
    assign w_off    = r_state - S_WAIT0;
    assign w_idx    = w_off[1:0];
    // Done beats a timeout landing on the same cycle.
    assign w_done   = w_inWait && unitDone[w_idx];
    assign w_tmo    = w_inWait && (r_waitCnt == TMO_LAST) && !w_done;
    assign w_toSet  = w_tmo ? (4'b0001 << w_idx) : 4'b0000;
    assign w_ovSet  = w_tick && (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_condPrev     <= 1'b1;
            r_waitCnt      <= '0;
            r_unitStart    <= '0;
            r_frameStart   <= 1'b0;
            r_timeoutFlags <= '0;
            r_overrun      <= 1'b0;
            r_frameCount   <= '0;
        end else begin
            r_condPrev   <= w_cond;
            r_unitStart  <= '0;
            r_frameStart <= 1'b0;
            // Set events override a simultaneous clear.
            r_timeoutFlags <= (clearFlags ? 4'b0000 : r_timeoutFlags) | w_toSet;
            r_overrun      <= (clearFlags ? 1'b0 : r_overrun) | w_ovSet;
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state     <= S_WAIT0;
                        r_unitStart <= 4'b0001;
                        r_waitCnt   <= '0;
                    end
                end
                S_WAIT0, S_WAIT1, S_WAIT2, S_WAIT3: begin
                    if (w_done || w_tmo) begin
                        r_waitCnt <= '0;
                        if (r_state == S_WAIT3) begin
                            r_state      <= S_COMMIT;
                            r_frameStart <= 1'b1;
                        end else begin
                            r_state     <= state_t'(r_state + 3'd1);
                            r_unitStart <= 4'b0010 << w_idx;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 16'd1;
                    end
                end
                S_COMMIT: begin
                    r_state      <= S_IDLE;
                    r_frameCount <= r_frameCount + 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign unitStart    = r_unitStart;
    assign frameStart   = r_frameStart;
    assign busy         = (r_state != S_IDLE);
    assign timeoutFlags = r_timeoutFlags;
    assign overrun      = r_overrun;
    assign frameCount   = r_frameCount;
endmodule

// File: tb/tb_frame_update_scheduler.sv
// Randomized bench for frame_update_scheduler; expected timing and flags come from
// per-unit delay arithmetic rather than a cycle-level copy of the sequencer.
module tb_frame_update_scheduler;
    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] hCount, vCount;
    logic [3:0] unitDone;
    logic       clearFlags;
    logic [3:0] unitStart;
    logic       frameStart, busy, overrun;
    logic [3:0] timeoutFlags;
    logic [7:0] frameCount;

    int       n_chk = 0;
    int       n_fail = 0;
    int       exp_fc = 0;
    bit [3:0] exp_to = '0;
    bit       exp_ov = 1'b0;

    frame_update_scheduler #(.TRIG_LINE(10'd480), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .hCount(hCount), .vCount(vCount),
        .unitDone(unitDone), .clearFlags(clearFlags), .unitStart(unitStart),
        .frameStart(frameStart), .busy(busy), .timeoutFlags(timeoutFlags),
        .overrun(overrun), .frameCount(frameCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cond(input bit on);
        if (on) begin
            hCount = 10'd0;
            vCount = 10'd480;
        end else begin
            hCount = 10'($urandom_range(0, 799));
            vCount = 10'($urandom_range(0, 524));
            if (hCount == 10'd0 && vCount == 10'd480) vCount = 10'd479;
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_tflags"}, int'(timeoutFlags), int'(exp_to));
        chk({tag, "_overrun"}, int'(overrun), int'(exp_ov));
        chk({tag, "_fcount"}, int'(frameCount), exp_fc);
    endtask

    // d*: cycles from a unit's start pulse to its done pulse (>= TO means never).
    // rt: cycle of a second trigger (-1 none); clr_at: clearFlags cycle (-1 none).
    // noise: 0 none, 1 random done bits on idle units, 2 fixed 4'b1000.
    task automatic run_frame(input int d0, input int d1, input int d2, input int d3,
                             input int hold, input int rt, input int clr_at,
                             input int noise, input string tag);
        int d[4];
        int s[4];
        int sc[4];
        int seen[4];
        int f, cur, fs_n, fs_at, busy_n;
        d = '{d0, d1, d2, d3};
        s[0] = 1;
        for (int i = 0; i < 3; i++) s[i+1] = s[i] + ((d[i] < TO-1) ? d[i] : TO-1) + 1;
        f = s[3] + ((d[3] < TO-1) ? d[3] : TO-1) + 1;
        for (int i = 0; i < 4; i++) begin sc[i] = -1; seen[i] = 0; end
        cur = -1; fs_n = 0; fs_at = -1; busy_n = 0;
        for (int n = 0; n <= f + 3; n++) begin
            chk({tag, "_onehot"}, int'($countones(unitStart) <= 1), 1);
            for (int i = 0; i < 4; i++)
                if (unitStart[i]) begin seen[i]++; sc[i] = n; cur = i; end
            if (frameStart) begin fs_n++; fs_at = n; end
            if (busy) busy_n++;
            set_cond((n < hold) || (n == rt));
            clearFlags = (n == clr_at);
            unitDone = (noise == 1) ? 4'($urandom) : (noise == 2) ? 4'b1000 : 4'b0000;
            if (cur >= 0) unitDone[cur] = (n - sc[cur] == d[cur]);
            step();
        end
        unitDone = '0;
        clearFlags = 1'b0;
        set_cond(1'b0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_start%0d_at", tag, i), sc[i], s[i]);
            chk($sformatf("%s_start%0d_cnt", tag, i), seen[i], 1);
        end
        chk({tag, "_fstart_at"}, fs_at, f);
        chk({tag, "_fstart_cnt"}, fs_n, 1);
        chk({tag, "_busy_cycles"}, busy_n, f);
        if (clr_at >= 0) begin exp_to = '0; exp_ov = 1'b0; end
        for (int i = 0; i < 4; i++)
            if (d[i] >= TO && (clr_at < 0 || s[i] + TO - 1 >= clr_at)) exp_to[i] = 1'b1;
        if (rt >= 1 && rt <= f && (clr_at < 0 || rt >= clr_at)) exp_ov = 1'b1;
        exp_fc = (exp_fc + 1) % 256;
        chk_state(tag);
    endtask

    task automatic reset_mid();
        int pulses;
        set_cond(1'b1); unitDone = '0;
        step();
        set_cond(1'b0);
        unitDone = unitStart & 4'b0011;
        step();
        unitDone = unitStart & 4'b0011;
        step();
        chk("rst_in_wait2", int'(unitStart), 4);
        unitDone = '0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_fc = 0; exp_to = '0; exp_ov = 1'b0;
        chk("rst_ustart", int'(unitStart), 0);
        chk("rst_fstart", int'(frameStart), 0);
        chk("rst_busy", int'(busy), 0);
        chk_state("rst");
        pulses = 0;
        for (int n = 0; n < 20; n++) begin
            pulses += int'(unitStart != 0) + int'(frameStart) + int'(busy);
            step();
        end
        chk("rst_no_activity", pulses, 0);
    endtask

    initial begin
        int d[4];
        int hold, rt, clr;
        set_cond(1'b1);
        unitDone = '0;
        clearFlags = 1'b0;
        repeat (3) step();
        chk("reset_ustart", int'(unitStart), 0);
        chk("reset_fstart", int'(frameStart), 0);
        chk("reset_busy", int'(busy), 0);
        chk_state("reset");
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("cond_at_release", int'(busy) + int'(unitStart != 0), 0);
        end
        set_cond(1'b0);
        step();

        run_frame(0, 0, 0, 0, 4, -1, -1, 0, "basic");
        run_frame(0, 0, TO + 5, 0, 1, -1, -1, 0, "tmo2");
        run_frame(0, 3, 0, 0, 1, 3, -1, 0, "retrig");
        run_frame(2, 0, 0, 0, 1, -1, -1, 2, "foreign_done");
        run_frame(0, TO - 1, 0, 0, 2, -1, -1, 0, "done_at_limit");
        run_frame(0, TO + 2, 0, 0, 1, -1, 9, 0, "clr_with_tmo1");
        run_frame(0, 0, 0, 0, 1, -1, 2, 0, "clr_only");

        for (int r = 0; r < 24; r++) begin
            for (int i = 0; i < 4; i++) d[i] = $urandom_range(0, TO + 1);
            hold = $urandom_range(1, 4);
            rt   = ($urandom_range(0, 1) == 1) ? $urandom_range(hold + 1, 5) : -1;
            clr  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 8) : -1;
            run_frame(d[0], d[1], d[2], d[3], hold, rt, clr, 1, "rand");
        end

        reset_mid();

        for (int r = 0; r < 256; r++)
            run_frame($urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2),
                      $urandom_range(0, 2), 1, -1, -1, 1, "wrap");
        chk("fcount_wrapped", int'(frameCount), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/frame_update_scheduler.md
FRAME_UPDATE_SCHEDULER -- requirements
Module: frame_update_scheduler

Interface
REQ-001 SHALL have parameter TRIG_LINE, default 10'd480, meaning the vCount value whose line start triggers a frame update.
REQ-002 SHALL have parameter TIMEOUT, default 1000, meaning the maximum number of cycles spent waiting on one unit (legal range 2..65535).
REQ-003 SHALL have port clk  input  1  system clock; the block uses one clock, and all logic is clocked on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port hCount  input  10  current horizontal pixel count.
REQ-006 SHALL have port vCount  input  10  current vertical line count.
REQ-007 SHALL have port unitDone  input  4  per-unit completion pulse; bit 0 is player, 1 blade, 2 lizard, 3 campfire.
REQ-008 SHALL have port clearFlags  input  1  clears the sticky error flags.
REQ-009 SHALL have port unitStart  output  4  registered one-cycle start pulse per unit.
REQ-010 SHALL have port frameStart  output  1  registered one-cycle commit pulse to the display controller's position latch.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have port timeoutFlags  output  4  sticky per-unit timeout flags.
REQ-013 SHALL have port overrun  output  1  sticky flag: a trigger arrived while the block was not IDLE.
REQ-014 SHALL have port frameCount  output  8  number of committed frames, wrapping.

Function
REQ-015 SHALL compute cond = (hCount == 0) && (vCount == TRIG_LINE).
REQ-016 SHALL register condPrev each cycle and define tick = cond && !condPrev (rising edge only); a condition held for several cycles yields exactly one tick.
REQ-017 SHALL implement the state sequence IDLE -> WAIT0 -> WAIT1 -> WAIT2 -> WAIT3 -> COMMIT -> IDLE, with fixed unit order 0, 1, 2, 3.
REQ-018 SHALL, on tick in IDLE, enter WAIT0 on the next edge; unitStart[0] is then high during the first WAIT0 cycle.
REQ-019 SHALL assert unitStart[i] only during the first cycle of each WAITi visit, and never more than one start bit at a time.
REQ-020 SHALL accept unitDone[i] in any WAITi cycle, including the cycle of the start pulse; unitDone bits for other units are ignored.
REQ-021 SHALL, on unitDone[i] in WAITi, advance to WAIT(i+1), or to COMMIT from WAIT3, on the next edge with no idle gap.
REQ-022 SHALL run a 16-bit wait counter that clears on WAITi entry and increments each WAITi cycle.
REQ-023 SHALL, if the counter equals TIMEOUT-1 without done, set timeoutFlags[i] and advance as in REQ-021.
REQ-024 SHALL let done win when done and timeout coincide in the same cycle: no flag is set.
REQ-025 SHALL, in COMMIT (exactly one cycle), drive frameStart=1 and increment frameCount modulo 256 (255 -> 0), then return to IDLE.
REQ-026 SHALL, on tick in any non-IDLE state including COMMIT, set overrun and ignore the tick: the sequence is neither restarted nor queued.
REQ-027 SHALL, on clearFlags, zero timeoutFlags and overrun on the next edge; a set event in the same cycle takes priority over the clear for that bit.
REQ-028 SHALL have a minimum latency, with all units done immediately, of tick at edge T -> unitStart[0] at T+1, unitStart[3] at T+4, frameStart at T+5.

Reset
REQ-029 SHALL, on reset, set state=IDLE, unitStart=0, frameStart=0, busy=0, timeoutFlags=0, overrun=0, frameCount=0, wait counter=0 and condPrev=1, so no tick occurs if cond is already true at reset release.
REQ-030 SHALL let reset mid-sequence abort immediately, with no frameStart pulse and no further unitStart pulses.

Verification
REQ-031 SHALL cover: vCount=480 with hCount=0 for 4 cycles, every unitDone tied to its unitStart -> one tick, starts at T+1..T+4, frameStart at T+5, frameCount=1.
REQ-032 SHALL cover: unit 2 done held low with TIMEOUT=8 -> timeoutFlags=4'b0100, unitStart[3] follows 8 cycles after unitStart[2], frame still commits.
REQ-033 SHALL cover: a second tick forced while in WAIT1 -> overrun=1, exactly one frameStart pulse, no restart.
REQ-034 SHALL cover: unitDone=4'b1000 while in WAIT0 -> ignored, state remains WAIT0.
REQ-035 SHALL cover: reset asserted during WAIT2 -> all outputs at reset values next cycle, no frameStart; 256 commits -> frameCount wraps to 0.
REQ-036 SHALL cover: clearFlags coinciding with a timeout of unit 1 -> timeoutFlags[1]=1 afterwards; clearFlags alone -> all flags 0.
